// File: rtl/writeback_queue.sv
// Four-entry in-order writeback queue in front of the register bank.
// Define WBQ_FORWARD_EN to forward queued data to reads instead of flagging hazards.
module writeback_queue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_sel,
    input  logic [15:0] wb_data,
    input  logic        rf_hold,
    output logic [2:0]  rf_write_choose,
    output logic        rf_in_or_not,
    output logic [15:0] rf_input_wire,
    input  logic [2:0]  rd_sel_one,
    input  logic [2:0]  rd_sel_two,
    input  logic [15:0] rf_out1,
    input  logic [15:0] rf_out2,
    output logic [15:0] rd_data_one,
    output logic [15:0] rd_data_two,
    output logic        rd_hazard_one,
    output logic        rd_hazard_two,
    output logic [2:0]  q_count
);

    logic [2:0]  sel_q  [4];
    logic [15:0] data_q [4];
    logic [1:0]  wptr_q, wptr_d;
    logic [1:0]  rptr_q, rptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        push, pop;

    assign wb_ready = (cnt_q != 3'd4);
    assign push     = wb_valid && wb_ready;
    assign pop      = (cnt_q != 3'd0) && !rf_hold;
    assign q_count  = cnt_q;

    assign rf_in_or_not    = pop;
    assign rf_write_choose = pop ? sel_q[rptr_q] : 3'd0;
    assign rf_input_wire   = pop ? data_q[rptr_q] : 16'd0;

    always_comb begin
        wptr_d = push ? wptr_q + 2'd1 : wptr_q;
        rptr_d = pop ? rptr_q + 2'd1 : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 3'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 3'd0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is left uncleared; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_q[wptr_q]  <= wb_sel;
            data_q[wptr_q] <= wb_data;
        end
    end

    logic        hit1, hit2;
    logic [1:0]  idx;
`ifdef WBQ_FORWARD_EN
    logic [15:0] fwd1, fwd2;
`endif

    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = rptr_q;
`ifdef WBQ_FORWARD_EN
        fwd1 = 16'd0;
        fwd2 = 16'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            idx = rptr_q + 2'(i);
            if (3'(i) < cnt_q) begin
                if (sel_q[idx] == rd_sel_one) begin
                    hit1 = 1'b1;
`ifdef WBQ_FORWARD_EN
                    fwd1 = data_q[idx];
`endif
                end
                if (sel_q[idx] == rd_sel_two) begin
                    hit2 = 1'b1;
`ifdef WBQ_FORWARD_EN
                    fwd2 = data_q[idx];
`endif
                end
            end
        end
    end

`ifdef WBQ_FORWARD_EN
    assign rd_data_one   = hit1 ? fwd1 : rf_out1;
    assign rd_data_two   = hit2 ? fwd2 : rf_out2;
    assign rd_hazard_one = 1'b0;
    assign rd_hazard_two = 1'b0;
`else
    assign rd_data_one   = rf_out1;
    assign rd_data_two   = rf_out2;
    assign rd_hazard_one = hit1;
    assign rd_hazard_two = hit2;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: scoreboard on commits,
// table-driven read-coherence vectors, hand-written corner sequences.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_sel;
    logic [15:0] wb_data;
    logic        rf_hold;
    logic [2:0]  rf_write_choose;
    logic        rf_in_or_not;
    logic [15:0] rf_input_wire;
    logic [2:0]  rd_sel_one, rd_sel_two;
    logic [15:0] rf_out1, rf_out2;
    logic [15:0] rd_data_one, rd_data_two;
    logic        rd_hazard_one, rd_hazard_two;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    writeback_queue dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_sel          (wb_sel),
        .wb_data         (wb_data),
        .rf_hold         (rf_hold),
        .rf_write_choose (rf_write_choose),
        .rf_in_or_not    (rf_in_or_not),
        .rf_input_wire   (rf_input_wire),
        .rd_sel_one      (rd_sel_one),
        .rd_sel_two      (rd_sel_two),
        .rf_out1         (rf_out1),
        .rf_out2         (rf_out2),
        .rd_data_one     (rd_data_one),
        .rd_data_two     (rd_data_two),
        .rd_hazard_one   (rd_hazard_one),
        .rd_hazard_two   (rd_hazard_two),
        .q_count         (q_count)
    );

    int errors = 0;
    int checks = 0;
    int commits = 0;
    logic [18:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs settle after posedge, so the negedge view
    // predicts exactly what the next edge will accept and commit.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (rf_in_or_not) begin
                commits++;
                if (sb.size() == 0) begin
                    chk("commit_unexpected", 32'(rf_write_choose), 32'h7fff);
                end else begin
                    chk("commit", {13'd0, rf_write_choose, rf_input_wire},
                        {13'd0, sb[0]});
                    void'(sb.pop_front());
                end
            end
            if (wb_valid && wb_ready) sb.push_back({wb_sel, wb_data});
        end
    end

    typedef struct {
        logic [2:0]  rs1, rs2;
        logic [15:0] o1, o2;
        logic        h1, h2;
        logic [15:0] f1, f2;
    } vec_t;
    vec_t tbl[4];

    task automatic push_one(input logic [2:0] s, input logic [15:0] d);
        wb_valid = 1'b1;
        wb_sel   = s;
        wb_data  = d;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        rf_hold  = 1'b0;
        wb_valid = 1'b0;
        while (q_count != 3'd0 && n < 20) begin
            tick();
            n++;
        end
        chk(nm, 32'(q_count), 32'd0);
    endtask

    initial begin
        logic [15:0] e1, e2;
        logic        z1, z2;
        int          c0;
        logic        acc;
        logic [15:0] nd;

        rst_n = 1'b0; wb_valid = 1'b0; wb_sel = '0; wb_data = '0;
        rf_hold = 1'b0; rd_sel_one = 3'd0; rd_sel_two = 3'd1;
        rf_out1 = 16'h1234; rf_out2 = 16'h5678;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 32'(wb_ready), 32'd1);
        chk("rst_count", 32'(q_count), 32'd0);
        chk("rst_we", 32'(rf_in_or_not), 32'd0);
        chk("rst_sel", 32'(rf_write_choose), 32'd0);
        chk("rst_wdata", 32'(rf_input_wire), 32'd0);
        chk("rst_haz1", 32'(rd_hazard_one), 32'd0);
        chk("rst_haz2", 32'(rd_hazard_two), 32'd0);
        chk("rst_rd1", 32'(rd_data_one), 32'h1234);
        chk("rst_rd2", 32'(rd_data_two), 32'h5678);

        // Single push, one-cycle latency
        push_one(3'd3, 16'h00AA);
        chk("lat_we", 32'(rf_in_or_not), 32'd1);
        chk("lat_sel", 32'(rf_write_choose), 32'd3);
        chk("lat_data", 32'(rf_input_wire), 32'h00AA);
        chk("lat_cnt", 32'(q_count), 32'd1);
        tick();
        chk("lat_cnt0", 32'(q_count), 32'd0);
        chk("lat_we0", 32'(rf_in_or_not), 32'd0);

        // Fill under hold, fifth request waits
        rf_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push_one(3'(k), 16'h0100 + 16'(k));
            chk("fill_cnt", 32'(q_count), 32'(k + 1));
            chk("fill_we", 32'(rf_in_or_not), 32'd0);
        end
        chk("full_ready", 32'(wb_ready), 32'd0);
        wb_valid = 1'b1; wb_sel = 3'd4; wb_data = 16'h0104;
        tick(); tick();
        chk("full_hold_cnt", 32'(q_count), 32'd4);
        chk("full_hold_rdy", 32'(wb_ready), 32'd0);
        rf_hold = 1'b0;
        tick();
        chk("release_cnt", 32'(q_count), 32'd3);
        chk("release_rdy", 32'(wb_ready), 32'd1);
        tick();
        wb_valid = 1'b0;
        chk("accept5_cnt", 32'(q_count), 32'd3);
        drain("drain1");

        // Continuous streaming from full
        rf_hold = 1'b1;
        for (int k = 0; k < 4; k++) push_one(3'(k + 4), 16'h2000 + 16'(k));
        rf_hold = 1'b0;
        wb_valid = 1'b1; nd = 16'h3000;
        wb_sel = 3'd1; wb_data = nd;
        c0 = commits;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            acc = wb_ready;
            chk("stream_cnt", 32'(q_count), (k == 0) ? 32'd4 : 32'd3);
            tick();
            if (acc) begin
                nd = nd + 16'h0011;
                wb_sel = wb_sel + 3'd3;
                wb_data = nd;
            end
        end
        wb_valid = 1'b0;
        chk("stream_commits", 32'(commits - c0), 32'd12);
        drain("drain2");

        // Read coherence: fill to full so the offered request stays out
        rf_hold = 1'b1;
        push_one(3'd2, 16'h1111);
        push_one(3'd5, 16'h3333);
        push_one(3'd2, 16'h2222);
        push_one(3'd7, 16'h4444);
        wb_valid = 1'b1; wb_sel = 3'd6; wb_data = 16'h6666;
        tbl[0] = '{3'd2, 3'd5, 16'hDEAD, 16'hBEEF, 1, 1, 16'h2222, 16'h3333};
        tbl[1] = '{3'd6, 3'd0, 16'hA5A5, 16'h5A5A, 0, 0, 16'h0, 16'h0};
        tbl[2] = '{3'd7, 3'd2, 16'h0F0F, 16'hF0F0, 1, 1, 16'h4444, 16'h2222};
        tbl[3] = '{3'd1, 3'd3, 16'hCAFE, 16'hFACE, 0, 0, 16'h0, 16'h0};
        for (int i = 0; i < 4; i++) begin
            rd_sel_one = tbl[i].rs1; rd_sel_two = tbl[i].rs2;
            rf_out1 = tbl[i].o1; rf_out2 = tbl[i].o2;
            #1;
`ifdef WBQ_FORWARD_EN
            e1 = tbl[i].h1 ? tbl[i].f1 : tbl[i].o1;
            e2 = tbl[i].h2 ? tbl[i].f2 : tbl[i].o2;
            z1 = 1'b0; z2 = 1'b0;
`else
            e1 = tbl[i].o1; e2 = tbl[i].o2;
            z1 = tbl[i].h1; z2 = tbl[i].h2;
`endif
            chk("vec_rd1", 32'(rd_data_one), 32'(e1));
            chk("vec_rd2", 32'(rd_data_two), 32'(e2));
            chk("vec_hz1", 32'(rd_hazard_one), 32'(z1));
            chk("vec_hz2", 32'(rd_hazard_two), 32'(z2));
        end
        wb_valid = 1'b0;
        rf_hold = 1'b0;
        tick();
        rf_hold = 1'b1;
        rd_sel_one = 3'd5; rf_out1 = 16'h9999;
        rf_hold = 1'b0;
        #1;
        chk("head_we", 32'(rf_in_or_not), 32'd1);
`ifdef WBQ_FORWARD_EN
        chk("head_rd1", 32'(rd_data_one), 32'h3333);
        chk("head_hz1", 32'(rd_hazard_one), 32'd0);
`else
        chk("head_rd1", 32'(rd_data_one), 32'h9999);
        chk("head_hz1", 32'(rd_hazard_one), 32'd1);
`endif
        drain("drain3");
        #1;
        chk("empty_hz1", 32'(rd_hazard_one), 32'd0);
        chk("empty_rd1", 32'(rd_data_one), 32'h9999);

        // Reset discards queued writes and the concurrent push
        rf_hold = 1'b1;
        push_one(3'd1, 16'hA001);
        push_one(3'd2, 16'hA002);
        push_one(3'd3, 16'hA003);
        chk("pre_rst_cnt", 32'(q_count), 32'd3);
        rst_n = 1'b0;
        wb_valid = 1'b1; wb_sel = 3'd4; wb_data = 16'hA004;
        tick();
        rst_n = 1'b1;
        wb_valid = 1'b0;
        rf_hold = 1'b0;
        #1;
        chk("rst_cnt", 32'(q_count), 32'd0);
        chk("rst_rdy", 32'(wb_ready), 32'd1);
        c0 = commits;
        for (int k = 0; k < 3; k++) begin
            chk("rst_no_we", 32'(rf_in_or_not), 32'd0);
            tick();
        end
        chk("rst_commits", 32'(commits - c0), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
